// File: rtl/tokens_pkg.sv
// rtl/tokens_pkg.sv - shared limits for the token doubling encoder and halving decoder
package tokens_pkg;
  localparam int MAX_TOKENS = 200;
  localparam int ORPHAN_TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/token_counter.sv
// rtl/token_counter.sv - saturating up/down counter with drop pulse on increment at full
module token_counter #(
  parameter int MAX = 200,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         drop
);
  logic [W-1:0] count_q, count_d;

  assign count = count_q;
  assign full  = (count_q == W'(MAX));
  assign drop  = inc && full && !dec;

  // Simultaneous inc/dec cancels, which keeps a full queue legal while draining.
  always_comb begin
    count_d = count_q;
    if (inc && !dec && !full)
      count_d = count_q + W'(1);
    else if (dec && !inc)
      count_d = count_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end
endmodule

// File: rtl/halve_tokens.sv
// rtl/halve_tokens.sv - decodes pairs of '1' tokens into a queued valid/ready token stream
module halve_tokens
  import tokens_pkg::*;
#(
  parameter int  MAX_PENDING    = MAX_TOKENS,
  parameter int  ORPHAN_TIMEOUT = ORPHAN_TIMEOUT_DEFAULT,
  localparam int W              = $clog2(MAX_PENDING + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         b,
  output logic         a_valid,
  input  logic         a_ready,
  output logic [W-1:0] pending,
  output logic         overflow,
  output logic         orphan
);
  localparam int IW = $clog2(ORPHAN_TIMEOUT + 1);

  logic          half_q, half_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          orphan_q, orphan_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, cnt_full, cnt_drop;

  assign push     = b && half_q;
  assign pop      = a_valid && a_ready;
  assign a_valid  = (pending != '0);
  assign overflow = overflow_q;
  assign orphan   = orphan_q;

  token_counter #(.MAX(MAX_PENDING), .W(W)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (push),
    .dec  (pop),
    .count(pending),
    .full (cnt_full),
    .drop (cnt_drop)
  );

  // A completing '1' wins over a timeout landing on the same edge.
  always_comb begin
    half_d     = half_q;
    idle_d     = idle_q;
    orphan_d   = orphan_q;
    overflow_d = overflow_q || (cnt_drop && cnt_full);
    if (b) begin
      half_d = ~half_q;
      idle_d = '0;
    end else if (!half_q) begin
      idle_d = '0;
    end else if (idle_q == IW'(ORPHAN_TIMEOUT)) begin
      orphan_d = 1'b1;
      half_d   = 1'b0;
      idle_d   = '0;
    end else begin
      idle_d = idle_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      half_q     <= 1'b0;
      idle_q     <= '0;
      orphan_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      half_q     <= half_d;
      idle_q     <= idle_d;
      orphan_q   <= orphan_d;
      overflow_q <= overflow_d;
    end
  end
endmodule
